vga_scanout: RTL and testbench

- Read side of the pixel framebuffer that the square-drawing datapath/control pair writes through (x 8-bit, y 7-bit, colour 3-bit, 160x120).
- Generates 640x480@60 VGA timing and fetches each 4x4-scaled pixel from the framebuffer read port.
- Drives DAC RGB, syncs and blank to the board VGA connector, 2 enabled cycles of pipeline.

---
 rtl/vga_scanout.sv | 104 ++++++++++
 tb/tb_vga_scanout.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing generator fetching a 4x-upscaled 160x120 framebuffer.
// Two enabled cycles from counter position to DAC outputs; syncs and blank share that delay.
module vga_scanout #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int FB_WIDTH    = 160
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    output logic [14:0] rd_addr,
    input  logic [2:0]  rd_data,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        frame_start
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [14:0]   rd_addr_q, rd_addr_d;
    logic [14:0]   fb_x, fb_y;
    logic          h_wrap, v_wrap;
    logic          vis0, hs0, vs0, first0;
    logic          vis1_q, hs1_q, vs1_q, first1_q;
    logic [7:0]    r_q, g_q, b_q;
    logic          hs_q, vs_q, blank_n_q, fs_q;

    always_comb begin
        h_wrap    = h_cnt_q == HW'(H_TOTAL - 1);
        v_wrap    = v_cnt_q == VW'(V_TOTAL - 1);
        h_cnt_d   = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d   = !h_wrap ? v_cnt_q : v_wrap ? '0 : v_cnt_q + 1'b1;
        vis0      = h_cnt_q < HW'(H_VISIBLE) && v_cnt_q < VW'(V_VISIBLE);
        hs0       = !(h_cnt_q >= HW'(HS_START) && h_cnt_q < HW'(HS_START + H_SYNC));
        vs0       = !(v_cnt_q >= VW'(VS_START) && v_cnt_q < VW'(VS_START + V_SYNC));
        first0    = h_cnt_q == '0 && v_cnt_q == '0;
        fb_x      = 15'(h_cnt_q >> SCALE_SHIFT);
        fb_y      = 15'(v_cnt_q >> SCALE_SHIFT);
        // Address holds through blanking so the memory sees no spurious reads.
        rd_addr_d = vis0 ? 15'(fb_y * 15'(FB_WIDTH)) + fb_x : rd_addr_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            rd_addr_q <= '0;
            vis1_q    <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            first1_q  <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            fs_q      <= 1'b0;
        end else if (enable) begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            rd_addr_q <= rd_addr_d;
            vis1_q    <= vis0;
            hs1_q     <= hs0;
            vs1_q     <= vs0;
            first1_q  <= first0;
            r_q       <= vis1_q ? {8{rd_data[2]}} : '0;
            g_q       <= vis1_q ? {8{rd_data[1]}} : '0;
            b_q       <= vis1_q ? {8{rd_data[0]}} : '0;
            hs_q      <= hs1_q;
            vs_q      <= vs1_q;
            blank_n_q <= vis1_q;
            fs_q      <= first1_q;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: checks vga_scanout against a position-based model with a shortened frame.
// Horizontal timing is full size; vertical timing is cut down so whole frames fit the run.
module tb_vga_scanout;
    localparam int VV = 8;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = 800;
    localparam int VT = VV + VF + VS + VB;
    localparam int F  = HT * VT;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;

    int en_mode = 2;
    int n = 0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    function automatic logic [2:0] fb(input int a);
        return (a == 1) ? 3'b101 : 3'(a ^ (a >> 3));
    endfunction

    function automatic int addr(input int h, input int v);
        return (v / 4) * 160 + h / 4;
    endfunction

    // Outputs implied by the number of enabled cycles since reset release.
    function automatic logic [43:0] model(input int k);
        int p, h, v, q;
        logic [14:0] a;
        logic [2:0] c;
        logic vis;
        a = '0;
        if (k > 0) begin
            q = (k - 1) % F;
            h = q % HT;
            v = q / HT;
            if (v >= VV) a = 15'(addr(639, VV - 1));
            else if (h >= 640) a = 15'(addr(639, v));
            else a = 15'(addr(h, v));
        end
        if (k < 2) return {a, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        p = (k - 2) % F;
        h = p % HT;
        v = p / HT;
        vis = h < 640 && v < VV;
        c = vis ? fb(addr(h, v)) : 3'b000;
        return {a, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}, !(h >= 656 && h < 752),
                !(v >= VV + VF && v < VV + VF + VS), vis, 1'b0, p == 0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (n=%0d t=%0t)", name, act, exp, n, $time);
        end
    endtask

    assign rd_data = fb(int'(rd_addr));

    vga_scanout #(.V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .rd_addr(rd_addr), .rd_data(rd_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge resetn) n <= !resetn ? 0 : enable ? n + 1 : n;

    initial forever begin
        @(posedge clk);
        #2;
        enable = en_mode == 1 ? 1'b1 : en_mode == 2 ? ~enable : 1'b0;
    end

    logic p_blank = 1'b0, p_hs = 1'b1, p_vs = 1'b1, p_fs = 1'b0, line_vis = 1'b0;
    int t_br = -1, t_hf = -1, t_vf = -1, t_fs = -1, c_hf = 0, m_hf = 0, bl_cnt = 0;

    always @(negedge clk) begin
        check("outputs", {vga_r[7:0] == vga_r ? rd_addr : rd_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs,
              vga_blank_n, vga_sync_n, frame_start}, model(n));
        if (resetn && n == 2404) check("addr_h3_v3", rd_addr, 15'd0);
        if (resetn && n == 3205) check("addr_h4_v4", rd_addr, 15'd161);
        if (resetn && n == 6240) check("addr_last_visible", rd_addr, 15'd319);
        if (resetn && n >= 2 && n <= 5) check("rgb_px0_3", {vga_r, vga_g, vga_b}, 24'h000000);
        if (resetn && n >= 6 && n <= 9) check("rgb_px4_7", {vga_r, vga_g, vga_b}, 24'hFF00FF);
        if (!resetn) begin
            t_br = -1; t_hf = -1; t_vf = -1; t_fs = -1; bl_cnt = 0; line_vis = 1'b0;
            p_blank = 1'b0; p_hs = 1'b1; p_vs = 1'b1; p_fs = 1'b0;
        end else begin
            if (frame_start && !p_fs) begin
                if (t_fs >= 0) begin
                    check("frame_period", n - t_fs, F);
                    check("lines_per_frame", bl_cnt, VV);
                end
                t_fs = n;
                bl_cnt = 0;
            end
            if (vga_blank_n && !p_blank) begin
                t_br = n;
                bl_cnt++;
                line_vis = 1'b1;
            end
            if (!vga_blank_n && p_blank && t_br >= 0) check("blank_width", n - t_br, 640);
            if (!vga_hs && p_hs) begin
                if (line_vis) check("hs_after_blank", n - t_br, 656);
                line_vis = 1'b0;
                if (t_hf >= 0) begin
                    check("line_period", n - t_hf, 800);
                    if (m_hf == en_mode) check("line_clks", cyc - c_hf, 800 * en_mode);
                end
                t_hf = n;
                c_hf = cyc;
                m_hf = en_mode;
            end
            if (vga_hs && !p_hs && t_hf >= 0) check("hs_width", n - t_hf, 96);
            if (!vga_vs && p_vs) t_vf = n;
            if (vga_vs && !p_vs && t_vf >= 0) check("vs_width", n - t_vf, VS * HT);
            p_blank = vga_blank_n; p_hs = vga_hs; p_vs = vga_vs; p_fs = frame_start;
        end
    end

    task automatic wait_first_frame;
        int k;
        k = 0;
        while (!frame_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("first_frame_start_n", n, 2);
    endtask

    initial begin
        int k;
        repeat (10) @(posedge clk);
        #3;
        resetn = 1'b1;
        en_mode = 1;
        wait_first_frame();
        repeat (F + 1000) @(posedge clk);
        #3;
        en_mode = 2;
        repeat (2 * F + 2000) @(posedge clk);
        #3;
        en_mode = 1;
        k = 0;
        while (n % F != 5 * HT + 300 && k < 2 * F) begin
            @(posedge clk);
            #3;
            k++;
        end
        check("reach_h300_v5", n % F, 5 * HT + 300);
        resetn = 1'b0;
        #1;
        check("mid_reset_outputs", {rd_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n,
              vga_sync_n, frame_start}, {15'd0, 24'h0, 5'b11000});
        repeat (3) @(posedge clk);
        #3;
        resetn = 1'b1;
        wait_first_frame();
        repeat (F + 1000) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
